audio_dac_serializer: RTL and testbench



---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_sample_fifo.sv | 72 +++++++
 rtl/audio_dac_serializer.sv | 115 +++++++++++
 tb/tb_audio_dac_serializer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S DAC serializer.
// Imported by the serializer top and its sample FIFO.
package audio_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int I2S_DELAY  = 1;

  typedef enum logic [1:0] {
    ALIGN,
    LEFT,
    RIGHT
  } state_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// Stereo-pair FIFO between the bursty producer and the codec frame.
// Ready is registered from the next level, so it never rises in a full cycle.
module audio_sample_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ready_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   lvl_q;
  logic [AW:0]   lvl_d;
  logic          rdy_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (lvl_q == (AW+1)'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign do_push = push_i && rdy_q;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    lvl_d = lvl_q;
    if (do_push && !do_pop) begin
      lvl_d = lvl_q + 1'b1;
    end else if (!do_push && do_pop) begin
      lvl_d = lvl_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      lvl_q <= lvl_d;
      rdy_q <= (lvl_d != (AW+1)'(DEPTH));
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign ready_o = rdy_q;
  assign level_o = lvl_q;

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S slave serializer: codec clocks are synchronized into clk and
// edge strobes drive a LEFT/RIGHT shifter fed from the sample FIFO.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             sample_left,
  input  logic [DATA_W-1:0]             sample_right,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          bclk,
  input  logic                          daclrck,
  output logic                          dacdat,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(DATA_W) + 1;

  logic [2:0]          bclk_q;
  logic [2:0]          lrck_q;
  logic                bclk_fall;
  logic                lrck_fall;
  logic                lrck_rise;

  logic [2*DATA_W-1:0] fifo_rd;
  logic                fifo_empty;
  logic                fifo_full;
  logic                fifo_rdy;

  state_e              state_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   hold_q;
  logic [CW-1:0]       cnt_q;
  logic [1:0]          dly_q;
  logic                dat_q;
  logic                uf_q;

  // [0],[1] synchronize; [2] is the edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_q <= '0;
      lrck_q <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], bclk};
      lrck_q <= {lrck_q[1:0], daclrck};
    end
  end

  assign bclk_fall = bclk_q[2] & ~bclk_q[1];
  assign lrck_fall = bclk_fall & lrck_q[2] & ~lrck_q[1];
  assign lrck_rise = bclk_fall & ~lrck_q[2] & lrck_q[1];

  audio_sample_fifo #(
    .W     (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (sample_valid),
    .wdata_i ({sample_left, sample_right}),
    .pop_i   (lrck_fall),
    .rdata_o (fifo_rd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .ready_o (fifo_rdy),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ALIGN;
      shift_q <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
      dat_q   <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      uf_q <= lrck_fall & fifo_empty;
      if (lrck_fall) begin
        state_q <= LEFT;
        shift_q <= fifo_empty ? '0 : fifo_rd[2*DATA_W-1:DATA_W];
        hold_q  <= fifo_empty ? '0 : fifo_rd[DATA_W-1:0];
        cnt_q   <= '0;
        dly_q   <= 2'(I2S_DELAY - 1);
      end else if (lrck_rise && state_q == LEFT) begin
        state_q <= RIGHT;
        shift_q <= hold_q;
        cnt_q   <= '0;
        dly_q   <= 2'(I2S_DELAY - 1);
      end else if (bclk_fall && state_q != ALIGN) begin
        // the edge cycle itself is the first delay slot
        if (dly_q != '0) begin
          dly_q <= dly_q - 1'b1;
        end else if (cnt_q < CW'(DATA_W)) begin
          dat_q   <= shift_q[DATA_W-1];
          shift_q <= {shift_q[DATA_W-2:0], 1'b0};
          cnt_q   <= cnt_q + 1'b1;
        end else begin
          dat_q <= 1'b0;
        end
      end
    end
  end

  assign dacdat       = dat_q;
  assign underflow    = uf_q;
  assign sample_ready = fifo_rdy & ~fifo_full;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: codec-side clock generator plus a
// pair-queue model predicting every bit the codec samples on BCLK rise.
`timescale 1ns/100ps
module tb_audio_dac_serializer;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int HALF  = 160;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] sample_left;
  logic [DW-1:0] sample_right;
  logic          sample_valid;
  logic          sample_ready;
  logic          bclk;
  logic          daclrck;
  logic          dacdat;
  logic          underflow;
  logic [2:0]    fifo_level;

  int n_err = 0;
  int n_chk = 0;
  int uf_cnt = 0;
  int exp_uf = 0;
  logic [2*DW-1:0] mq [$];
  logic prev_bit;

  always #10 clk = ~clk;

  audio_dac_serializer #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .daclrck      (daclrck),
    .dacdat       (dacdat),
    .underflow    (underflow),
    .fifo_level   (fifo_level)
  );

  always @(posedge clk) begin
    if (underflow === 1'b1) uf_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] l,
                      input logic [DW-1:0] r);
    logic acc;
    @(negedge clk);
    acc = (mq.size() < DEPTH);
    check("push_rdy", sample_ready, acc);
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    if (acc) mq.push_back({l, r});
    check("push_lvl", fifo_level, mq.size());
  endtask

  // Drives nf I2S frames of `slot` BCLKs per channel; optional reset
  // after the rise of bit k == abort_k in the first left slot.
  task automatic run_frames(input int nf, input int slot,
                            input int ph, input int abort_k);
    logic [2*DW-1:0] pr;
    logic [DW-1:0]   w;
    logic            dead;
    logic            e;
    pr = '0;
    dead = 1'b0;
    @(posedge clk);
    #(ph + 0.5);
    for (int f = 0; f < nf; f++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (ch == 0) begin
          dead = 1'b0;
          if (mq.size() > 0) begin
            pr = mq.pop_front();
          end else begin
            pr = '0;
            exp_uf++;
          end
          w = pr[2*DW-1:DW];
        end else begin
          w = dead ? '0 : pr[DW-1:0];
        end
        for (int k = 1; k <= slot; k++) begin
          bclk = 1'b0;
          if (k == 1) daclrck = ch[0];
          #HALF;
          if (dead) e = 1'b0;
          else if (k == 1) e = prev_bit;
          else if (k <= DW + 1) e = w[DW+1-k];
          else e = 1'b0;
          bclk = 1'b1;
          check("dat", dacdat, e);
          prev_bit = e;
          if (f == 0 && ch == 0 && k == abort_k) begin
            reset = 1'b1;
            #40;
            check("rst_mid_dat", dacdat, 0);
            check("rst_mid_lvl", fifo_level, 0);
            reset = 1'b0;
            #(HALF - 40);
            dead = 1'b1;
            prev_bit = 1'b0;
            mq.delete();
          end else begin
            #HALF;
          end
        end
      end
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int uf0;
    logic [DW-1:0] l5;
    logic [DW-1:0] r5;
    sample_valid = 1'b0;
    sample_left  = '0;
    sample_right = '0;
    bclk         = 1'b1;
    daclrck      = 1'b1;
    prev_bit     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dat", dacdat, 0);
    check("rst_uf", underflow, 0);
    check("rst_lvl", fifo_level, 0);
    check("rst_rdy", sample_ready, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rdy_post_rst", sample_ready, 1);
    repeat (2) @(posedge clk);

    push(16'h8001, 16'h7FFE);
    run_frames(1, 32, 3, 0);
    check("t1_lvl", fifo_level, 0);

    uf0 = uf_cnt;
    run_frames(3, 32, 7, 0);
    check("t2_uf", uf_cnt - uf0, 3);
    check("t2_lvl", fifo_level, 0);

    for (int i = 0; i < 4; i++) begin
      push(DW'($urandom), DW'($urandom));
    end
    check("t3_full_lvl", fifo_level, 4);
    check("t3_full_rdy", sample_ready, 0);
    l5 = DW'($urandom);
    r5 = DW'($urandom);
    @(negedge clk);
    sample_left  = l5;
    sample_right = r5;
    sample_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t3_hold_lvl", fifo_level, 4);
    check("t3_hold_rdy", sample_ready, 0);
    sample_valid = 1'b0;
    run_frames(1, 32, 11, 0);
    check("t3_pop_lvl", fifo_level, 3);
    check("t3_pop_rdy", sample_ready, 1);
    push(l5, r5);
    check("t3_refull_rdy", sample_ready, 0);
    run_frames(4, 32, int'($urandom_range(0, 19)), 0);
    check("t3_drain_lvl", fifo_level, 0);

    push(16'hA5A5, 16'h5A5A);
    push(16'h1111, 16'h2222);
    run_frames(1, 32, 5, 8);
    check("t4_flush_lvl", fifo_level, 0);
    repeat (2) @(posedge clk);
    push(16'h1357, 16'h2468);
    run_frames(1, 32, 9, 0);

    push(16'hFFFF, DW'($urandom));
    run_frames(1, 12, 2, 0);
    run_frames(1, 32, 4, 0);

    for (int p = 0; p < 20; p++) begin
      push(DW'($urandom), DW'($urandom));
      run_frames(1, 32, p, 0);
    end

    check("uf_total", uf_cnt, exp_uf);
    check("end_lvl", fifo_level, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
